// File: rtl/ex_stage.sv
// Execute stage: operand forwarding muxes, ALU and the EX/MEM pipeline register.
// Define EX_STAGE_MUL_EN to add the iterative shift-add multiplier for op 1010.
module ex_stage #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        fwd_A,
  input  logic [1:0]        fwd_B,
  input  logic [DATA_W-1:0] id_ex_rs1_data,
  input  logic [DATA_W-1:0] id_ex_rs2_data,
  input  logic [DATA_W-1:0] id_ex_imm,
  input  logic              id_ex_alu_src,
  input  logic [3:0]        id_ex_alu_op,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              id_ex_regwrite,
  input  logic              id_ex_memread,
  input  logic              id_ex_memwrite,
  input  logic              id_ex_memtoreg,
  input  logic              id_ex_valid,
  input  logic [DATA_W-1:0] mem_wb_wb_data,
  input  logic              flush,
  output logic [DATA_W-1:0] ex_mem_alu_result,
  output logic [DATA_W-1:0] ex_mem_store_data,
  output logic [REG_AW-1:0] ex_mem_rd,
  output logic              ex_mem_regwrite,
  output logic              ex_mem_memread,
  output logic              ex_mem_memwrite,
  output logic              ex_mem_memtoreg,
  output logic              ex_mem_valid,
  output logic              ex_mem_zero,
  output logic              ex_busy
);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpAnd  = 4'b0010;
  localparam logic [3:0] OpOr   = 4'b0011;
  localparam logic [3:0] OpXor  = 4'b0100;
  localparam logic [3:0] OpSll  = 4'b0101;
  localparam logic [3:0] OpSrl  = 4'b0110;
  localparam logic [3:0] OpSra  = 4'b0111;
  localparam logic [3:0] OpSlt  = 4'b1000;
  localparam logic [3:0] OpSltu = 4'b1001;

  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_fwd_b;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_alu_res;
  logic [DATA_W-1:0] w_result;
  logic [2:0]        w_shamt;
  logic              w_busy;
  logic              w_load;

  logic [DATA_W-1:0] r_alu_result;
  logic [DATA_W-1:0] r_store_data;
  logic [REG_AW-1:0] r_rd;
  logic              r_regwrite;
  logic              r_memread;
  logic              r_memwrite;
  logic              r_memtoreg;
  logic              r_valid;
  logic              r_zero;

  // Select 11 falls back to the ID/EX value.
  always_comb begin
    case (fwd_A)
      2'b10:   w_op_a = r_alu_result;
      2'b01:   w_op_a = mem_wb_wb_data;
      default: w_op_a = id_ex_rs1_data;
    endcase
    case (fwd_B)
      2'b10:   w_fwd_b = r_alu_result;
      2'b01:   w_fwd_b = mem_wb_wb_data;
      default: w_fwd_b = id_ex_rs2_data;
    endcase
    w_alu_b = id_ex_alu_src ? id_ex_imm : w_fwd_b;
  end

  assign w_shamt = w_alu_b[2:0];

  // Op 1010 yields 0 here; the product only comes from the multiplier path.
  always_comb begin
    w_alu_res = '0;
    case (id_ex_alu_op)
      OpAdd:  w_alu_res = w_op_a + w_alu_b;
      OpSub:  w_alu_res = w_op_a - w_alu_b;
      OpAnd:  w_alu_res = w_op_a & w_alu_b;
      OpOr:   w_alu_res = w_op_a | w_alu_b;
      OpXor:  w_alu_res = w_op_a ^ w_alu_b;
      OpSll:  w_alu_res = w_op_a << w_shamt;
      OpSrl:  w_alu_res = w_op_a >> w_shamt;
      OpSra:  w_alu_res = $signed(w_op_a) >>> w_shamt;
      OpSlt:  w_alu_res = {{(DATA_W-1){1'b0}}, $signed(w_op_a) < $signed(w_alu_b)};
      OpSltu: w_alu_res = {{(DATA_W-1){1'b0}}, w_op_a < w_alu_b};
      default: w_alu_res = '0;
    endcase
  end

`ifdef EX_STAGE_MUL_EN
  localparam logic [3:0] OpMul = 4'b1010;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            r_state, w_state_nxt;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_mul_a, w_mul_a_nxt;
  logic [DATA_W-1:0] r_mul_b, w_mul_b_nxt;
  logic [DATA_W-1:0] r_acc, w_acc_nxt;
  logic [DATA_W-1:0] w_mul_sum;
  logic              w_mul_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mul_a <= w_mul_a_nxt;
      r_mul_b <= w_mul_b_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mul_a_nxt = r_mul_a;
    w_mul_b_nxt = r_mul_b;
    w_acc_nxt   = r_acc;
    w_busy      = 1'b0;
    w_mul_done  = 1'b0;
    w_mul_sum   = r_acc + (r_mul_b[r_cnt] ? (r_mul_a << r_cnt) : '0);
    if (flush) begin
      w_state_nxt = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          if (id_ex_valid && (id_ex_alu_op == OpMul)) begin
            w_busy      = 1'b1;
            w_state_nxt = StRun;
            w_cnt_nxt   = '0;
            w_mul_a_nxt = w_op_a;
            w_mul_b_nxt = w_alu_b;
            w_acc_nxt   = '0;
          end
        end
        StRun: begin
          w_acc_nxt = w_mul_sum;
          w_cnt_nxt = r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            w_mul_done  = 1'b1;
            w_state_nxt = StIdle;
          end else begin
            w_busy = 1'b1;
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  assign w_result = w_mul_done ? w_mul_sum : w_alu_res;
  // Reset holds the FSM in IDLE, where a presented MUL would otherwise raise busy.
  assign ex_busy  = w_busy & rst_n;
`else
  assign w_busy   = 1'b0;
  assign w_result = w_alu_res;
  assign ex_busy  = 1'b0;
`endif

  assign w_load = ~flush & ~w_busy;

  // Bubbles clear only the control bits that have architectural side effects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_result <= '0;
      r_store_data <= '0;
      r_rd         <= '0;
      r_regwrite   <= 1'b0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_valid      <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      r_alu_result <= w_result;
      r_store_data <= w_fwd_b;
      r_rd         <= id_ex_rd;
      r_memtoreg   <= id_ex_memtoreg;
      r_zero       <= (w_result == '0);
      r_valid      <= w_load & id_ex_valid;
      r_regwrite   <= w_load & id_ex_valid & id_ex_regwrite;
      r_memread    <= w_load & id_ex_valid & id_ex_memread;
      r_memwrite   <= w_load & id_ex_valid & id_ex_memwrite;
    end
  end

  assign ex_mem_alu_result = r_alu_result;
  assign ex_mem_store_data = r_store_data;
  assign ex_mem_rd         = r_rd;
  assign ex_mem_regwrite   = r_regwrite;
  assign ex_mem_memread    = r_memread;
  assign ex_mem_memwrite   = r_memwrite;
  assign ex_mem_memtoreg   = r_memtoreg;
  assign ex_mem_valid      = r_valid;
  assign ex_mem_zero       = r_zero;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized ALU traffic
// against an arithmetic reference model. MUL scenarios run when EX_STAGE_MUL_EN is defined.
module tb_ex_stage;

  logic       clk;
  logic       rst_n;
  logic [1:0] fwd_A, fwd_B;
  logic [7:0] id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic       id_ex_alu_src;
  logic [3:0] id_ex_alu_op;
  logic [4:0] id_ex_rd;
  logic       id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg, id_ex_valid;
  logic [7:0] mem_wb_wb_data;
  logic       flush;
  logic [7:0] ex_mem_alu_result, ex_mem_store_data;
  logic [4:0] ex_mem_rd;
  logic       ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite, ex_mem_memtoreg;
  logic       ex_mem_valid, ex_mem_zero, ex_busy;

  int checks = 0;
  int errors = 0;

  ex_stage #(.DATA_W(8), .REG_AW(5)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fwd_A             (fwd_A),
    .fwd_B             (fwd_B),
    .id_ex_rs1_data    (id_ex_rs1_data),
    .id_ex_rs2_data    (id_ex_rs2_data),
    .id_ex_imm         (id_ex_imm),
    .id_ex_alu_src     (id_ex_alu_src),
    .id_ex_alu_op      (id_ex_alu_op),
    .id_ex_rd          (id_ex_rd),
    .id_ex_regwrite    (id_ex_regwrite),
    .id_ex_memread     (id_ex_memread),
    .id_ex_memwrite    (id_ex_memwrite),
    .id_ex_memtoreg    (id_ex_memtoreg),
    .id_ex_valid       (id_ex_valid),
    .mem_wb_wb_data    (mem_wb_wb_data),
    .flush             (flush),
    .ex_mem_alu_result (ex_mem_alu_result),
    .ex_mem_store_data (ex_mem_store_data),
    .ex_mem_rd         (ex_mem_rd),
    .ex_mem_regwrite   (ex_mem_regwrite),
    .ex_mem_memread    (ex_mem_memread),
    .ex_mem_memwrite   (ex_mem_memwrite),
    .ex_mem_memtoreg   (ex_mem_memtoreg),
    .ex_mem_valid      (ex_mem_valid),
    .ex_mem_zero       (ex_mem_zero),
    .ex_busy           (ex_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU from the arithmetic definition of each operation.
  function automatic logic [7:0] model_alu(input logic [3:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    int ua, ub, sa, sb, sh, r;
    ua = a; ub = b;
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    sh = ub % 8;
    case (op)
      4'd0: r = (ua + ub) % 256;
      4'd1: r = (ua - ub + 256) % 256;
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: r = (ua * (1 << sh)) % 256;
      4'd6: r = ua / (1 << sh);
      4'd7: r = (sa >>> sh) & 255;
      4'd8: r = (sa < sb) ? 1 : 0;
      4'd9: r = (ua < ub) ? 1 : 0;
`ifdef EX_STAGE_MUL_EN
      4'd10: r = (ua * ub) % 256;
`endif
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] r1, input logic [7:0] r2,
                       input logic [7:0] imm, input logic src, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [7:0] wb, input logic v);
    id_ex_alu_op   = op;
    id_ex_rs1_data = r1;
    id_ex_rs2_data = r2;
    id_ex_imm      = imm;
    id_ex_alu_src  = src;
    fwd_A          = fa;
    fwd_B          = fb;
    mem_wb_wb_data = wb;
    id_ex_valid    = v;
    id_ex_rd       = 5'd7;
    id_ex_regwrite = 1'b1;
    id_ex_memread  = 1'b0;
    id_ex_memwrite = 1'b0;
    id_ex_memtoreg = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic test_reset();
    logic [26:0] obs;
    rst_n = 1'b0;
    drive(4'd0, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b0);
    #3;
    obs = {ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ex_mem_regwrite, ex_mem_memread,
           ex_mem_memwrite, ex_mem_memtoreg, ex_mem_valid, ex_mem_zero};
    checks++;
    if (obs !== 27'd0 || ex_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got %h busy %b, want 0 busy 0", obs, ex_busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_forwarding();
    logic [1:0] sels [4];
    logic [7:0] exps [4];
    sels = '{2'b00, 2'b10, 2'b01, 2'b11};
    exps = '{8'h08, 8'h13, 8'h23, 8'h08};
    for (int k = 0; k < 4; k++) begin
      drive(4'd0, 8'h10, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 8'h20, 1'b1);
      tick();
      drive(4'd0, 8'h05, 8'h03, 8'h00, 1'b0, sels[k], 2'b00, 8'h20, 1'b1);
      tick();
      checks++;
      if (ex_mem_alu_result !== exps[k]) begin
        errors++;
        $display("FAIL fwd_A_%b: got %h want %h", sels[k], ex_mem_alu_result, exps[k]);
      end
    end
  endtask

  task automatic test_imm_store();
    drive(4'd0, 8'h01, 8'h99, 8'h7F, 1'b1, 2'b00, 2'b01, 8'h55, 1'b1);
    id_ex_memwrite = 1'b1;
    id_ex_regwrite = 1'b0;
    tick();
    checks++;
    if (ex_mem_alu_result !== 8'h80 || ex_mem_store_data !== 8'h55 || ex_mem_zero !== 1'b0 ||
        ex_mem_memwrite !== 1'b1 || ex_mem_regwrite !== 1'b0) begin
      errors++;
      $display("FAIL imm_store: got res %h st %h z %b mw %b rw %b, want 80 55 0 1 0",
               ex_mem_alu_result, ex_mem_store_data, ex_mem_zero, ex_mem_memwrite,
               ex_mem_regwrite);
    end
  endtask

  task automatic test_shift_compare();
    drive(4'd7, 8'h80, 8'h03, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b1);
    tick();
    checks++;
    if (ex_mem_alu_result !== 8'hF0) begin
      errors++;
      $display("FAIL sra: got %h want f0", ex_mem_alu_result);
    end
    drive(4'd8, 8'hFF, 8'h01, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b1);
    tick();
    checks++;
    if (ex_mem_alu_result !== 8'h01 || ex_mem_zero !== 1'b0) begin
      errors++;
      $display("FAIL slt: got %h z %b want 01 z 0", ex_mem_alu_result, ex_mem_zero);
    end
    drive(4'd9, 8'hFF, 8'h01, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b1);
    tick();
    checks++;
    if (ex_mem_alu_result !== 8'h00 || ex_mem_zero !== 1'b1) begin
      errors++;
      $display("FAIL sltu: got %h z %b want 00 z 1", ex_mem_alu_result, ex_mem_zero);
    end
  endtask

  task automatic test_random();
    logic [7:0]  prev, a, fb, b, res;
    logic [26:0] obs, exp;
    logic        rw, mr, mw, mt, v;
    logic [4:0]  rd;
    drive(4'd0, 8'h00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b1);
    tick();
    prev = 8'h00;
    for (int i = 0; i < 60; i++) begin
`ifdef EX_STAGE_MUL_EN
      id_ex_alu_op = 4'($urandom_range(0, 9));
`else
      id_ex_alu_op = 4'($urandom_range(0, 15));
`endif
      id_ex_rs1_data = 8'($urandom);
      id_ex_rs2_data = 8'($urandom);
      id_ex_imm      = 8'($urandom);
      mem_wb_wb_data = 8'($urandom);
      id_ex_alu_src  = 1'($urandom);
      fwd_A          = 2'($urandom);
      fwd_B          = 2'($urandom);
      rd = 5'($urandom); rw = 1'($urandom); mr = 1'($urandom);
      mw = 1'($urandom); mt = 1'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      id_ex_rd = rd; id_ex_regwrite = rw; id_ex_memread = mr;
      id_ex_memwrite = mw; id_ex_memtoreg = mt; id_ex_valid = v;
      flush = 1'b0;
      a  = (fwd_A == 2'b10) ? prev : (fwd_A == 2'b01) ? mem_wb_wb_data : id_ex_rs1_data;
      fb = (fwd_B == 2'b10) ? prev : (fwd_B == 2'b01) ? mem_wb_wb_data : id_ex_rs2_data;
      b  = id_ex_alu_src ? id_ex_imm : fb;
      res = model_alu(id_ex_alu_op, a, b);
      #1;
      checks++;
      if (ex_busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_busy_%0d: got %b want 0", i, ex_busy);
      end
      tick();
      exp = {res, fb, rd, v & rw, v & mr, v & mw, mt, v, res == 8'h00};
      obs = {ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ex_mem_regwrite, ex_mem_memread,
             ex_mem_memwrite, ex_mem_memtoreg, ex_mem_valid, ex_mem_zero};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rand_%0d op %0d: got %h want %h", i, id_ex_alu_op, obs, exp);
      end
      prev = res;
    end
  endtask

`ifdef EX_STAGE_MUL_EN
  task automatic test_mul();
    logic [7:0] xa [2];
    logic [7:0] xb [2];
    logic [7:0] want;
    xa = '{8'h0D, 8'h07};
    xb = '{8'h0B, 8'h09};
    // Second MUL is presented in the cycle right after the first completes.
    for (int m = 0; m < 2; m++) begin
      drive(4'd10, xa[m], xb[m], 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b1);
      want = 8'((int'(xa[m]) * int'(xb[m])) % 256);
      for (int c = 0; c < 8; c++) begin
        checks++;
        if (ex_busy !== 1'b1) begin
          errors++;
          $display("FAIL mul%0d_busy_c%0d: got %b want 1", m, c, ex_busy);
        end
        tick();
        checks++;
        if (ex_mem_valid !== 1'b0) begin
          errors++;
          $display("FAIL mul%0d_bubble_c%0d: got %b want 0", m, c, ex_mem_valid);
        end
        if (c < 6) id_ex_rs1_data = 8'($urandom);
        else id_ex_rs1_data = xa[m];
      end
      checks++;
      if (ex_busy !== 1'b0) begin
        errors++;
        $display("FAIL mul%0d_busy_c8: got %b want 0", m, ex_busy);
      end
      tick();
      checks++;
      if (ex_mem_alu_result !== want || ex_mem_valid !== 1'b1) begin
        errors++;
        $display("FAIL mul%0d_result: got %h v %b want %h v 1", m, ex_mem_alu_result,
                 ex_mem_valid, want);
      end
    end
  endtask

  task automatic test_flush_mul();
    drive(4'd10, 8'h0D, 8'h0B, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b1);
    tick();
    tick();
    tick();
    flush = 1'b1;
    #1;
    checks++;
    if (ex_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: got %b want 0", ex_busy);
    end
    tick();
    checks++;
    if (ex_mem_valid !== 1'b0 || ex_mem_regwrite !== 1'b0) begin
      errors++;
      $display("FAIL flush_bubble: got v %b rw %b want 0 0", ex_mem_valid, ex_mem_regwrite);
    end
    drive(4'd0, 8'h03, 8'h04, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b1);
    #1;
    checks++;
    if (ex_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got busy %b want 0", ex_busy);
    end
    tick();
    checks++;
    if (ex_mem_alu_result !== 8'h07 || ex_mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_then_add: got %h v %b want 07 v 1", ex_mem_alu_result,
               ex_mem_valid);
    end
  endtask
`endif

  task automatic test_async_reset();
    logic [26:0] obs;
    drive(4'd0, 8'h21, 8'h11, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b1);
    id_ex_memwrite = 1'b1;
    tick();
`ifdef EX_STAGE_MUL_EN
    drive(4'd10, 8'h05, 8'h06, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b1);
    tick();
    tick();
`endif
    #2;
    rst_n = 1'b0;
    #1;
    obs = {ex_mem_alu_result, ex_mem_store_data, ex_mem_rd, ex_mem_regwrite, ex_mem_memread,
           ex_mem_memwrite, ex_mem_memtoreg, ex_mem_valid, ex_mem_zero};
    checks++;
    if (obs !== 27'd0 || ex_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %h busy %b want 0 busy 0", obs, ex_busy);
    end
    tick();
    rst_n = 1'b1;
    drive(4'd0, 8'h02, 8'h03, 8'h00, 1'b0, 2'b00, 2'b00, 8'h00, 1'b1);
    tick();
    checks++;
    if (ex_mem_alu_result !== 8'h05 || ex_mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_add: got %h v %b want 05 v 1", ex_mem_alu_result,
               ex_mem_valid);
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_imm_store();
    test_shift_compare();
    test_random();
`ifdef EX_STAGE_MUL_EN
    test_mul();
    test_flush_mul();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 8-bit RISC-V pipeline. It consumes the `fwd_A`/`fwd_B` selects from the forwarding unit and picks each ALU operand from the ID/EX register, the EX/MEM result or the MEM/WB write-back data. It computes the ALU result and captures result, store data and control into the EX/MEM pipeline register. An optional iterative multiplier stalls upstream while it runs.

## Interface
- `DATA_W`, 8, datapath width
- `REG_AW`, 5, register-address width
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous and active-low; one clock
- `fwd_A`, `fwd_B`  in  2  operand selects: 00 = ID/EX data, 10 = EX/MEM result, 01 = MEM/WB data, 11 = treated as 00
- `id_ex_rs1_data`, `id_ex_rs2_data`, `id_ex_imm`  in  DATA_W  ID/EX operands
- `id_ex_alu_src`  in  1  1 = operand B is `id_ex_imm`
- `id_ex_alu_op`  in  4  operation code
- `id_ex_rd`  in  REG_AW  destination register
- `id_ex_regwrite`, `id_ex_memread`, `id_ex_memwrite`, `id_ex_memtoreg`, `id_ex_valid`  in  1 each  ID/EX control
- `mem_wb_wb_data`  in  DATA_W  MEM/WB write-back value
- `flush`  in  1  synchronous squash of the instruction in EX
- `ex_mem_alu_result`, `ex_mem_store_data`  out  DATA_W  EX/MEM register; `ex_mem_alu_result` is also the internal 10 forwarding source
- `ex_mem_rd`  out  REG_AW
- `ex_mem_regwrite`, `ex_mem_memread`, `ex_mem_memwrite`, `ex_mem_memtoreg`, `ex_mem_valid`, `ex_mem_zero`  out  1 each
- `ex_busy`  out  1  combinational; upstream holds ID/EX and the forwarding inputs while it is high

## Operation
- Operand A is rs1 data, chosen by `fwd_A` from the three sources.
- Forwarded B is rs2 data, chosen by `fwd_B`. It goes straight to `ex_mem_store_data` and ignores `alu_src`.
- ALU operand B is `id_ex_imm` when `alu_src` = 1, otherwise forwarded B.
- Op codes:
  - 0000 ADD, 0001 SUB: mod 2^DATA_W, no carry out
  - 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA: shift amount = B[2:0]
  - 1000 SLT (signed), 1001 SLTU: result is 1 or 0
  - 1010 MUL: low DATA_W bits of the product; only with `MUL_EN`
  - All other codes give result 0.
- `ex_mem_zero` is registered as (result == 0).
- Each rising edge with no flush, no reset and `ex_busy` = 0 loads EX/MEM from ID/EX control plus the computed values.
  - `id_ex_valid` = 0 loads a bubble. A bubble has `valid`, `regwrite`, `memread` and `memwrite` all 0; data fields still load.
- Each rising edge with `ex_busy` = 1 loads a bubble.
- `flush` = 1 (highest priority after reset):
  - EX/MEM loads a bubble.
  - Multiplier FSM goes to IDLE.
  - `ex_busy` = 0 in that cycle.
- Reset: every EX/MEM output is 0, FSM is IDLE, `ex_busy` is 0. Reset mid-multiply abandons the operation.

## Timing
- ALU ops: EX/MEM updates at the first rising edge after the instruction is presented. Latency is 1, throughput 1 per cycle.
- MUL FSM has states IDLE and RUN, plus a 3-bit counter `cnt`.
  - IDLE with `valid` and op = 1010: latch A and B, go to RUN with `cnt` = 0. `ex_busy` is 1 in this cycle.
  - RUN: one shift-add step per cycle, `cnt` increments. `ex_busy` = 1 while `cnt` != 7.
  - RUN with `cnt` = 7: `ex_busy` = 0. At that edge the product and ID/EX control are written to EX/MEM and the FSM returns to IDLE.
- MUL presented in cycle 0 means `ex_busy` is high in cycles 0–7 and the result is visible in EX/MEM after the edge that ends cycle 8. Latency is 9.
- While in RUN, the ID/EX inputs are ignored. Operands were latched in cycle 0, so forwarding changes during RUN have no effect.
- Back-to-back MULs: the second is accepted in the cycle after the first completes.

## Configuration
- `EX_STAGE_MUL_EN` defined: multiplier FSM present and op 1010 multiplies.
- `EX_STAGE_MUL_EN` undefined: no FSM or counter, `ex_busy` tied to 0, op 1010 gives result 0 with latency 1.

## Test plan
- Forwarding select: rs1 = 0x05, EX/MEM result = 0x10, MEM/WB data = 0x20, rs2 = 0x03, ADD.
  - `fwd_A` 00 / 10 / 01 / 11 → `ex_mem_alu_result` = 0x08 / 0x13 / 0x23 / 0x08 on the next edge.
- Immediate and store data: `alu_src` = 1, imm = 0x7F, rs1 = 0x01, ADD, `fwd_B` = 01 with MEM/WB data = 0x55, `memwrite` = 1.
  - → result 0x80, `ex_mem_store_data` 0x55, `ex_mem_zero` 0.
- Shifts and compares:
  - SRA 0x80 by 3 → 0xF0.
  - SLT 0xFF vs 0x01 → 0x01.
  - SLTU 0xFF vs 0x01 → 0x00, `zero` = 1.
- MUL (`EX_STAGE_MUL_EN` defined): 0x0D × 0x0B presented in cycle 0.
  - → `ex_busy` high in cycles 0–7; `ex_mem_valid` 0 after the edges ending cycles 0–7.
  - → after the edge ending cycle 8: `ex_mem_alu_result` 0x8F, `valid` 1.
- Flush during a MUL: assert `flush` in cycle 3.
  - → `ex_busy` 0 in cycle 3, EX/MEM bubble, FSM IDLE; a following ADD completes with latency 1.
- Reset: drop `rst_n` mid-operation, asynchronous to `clk`.
  - → all EX/MEM outputs 0 and `ex_busy` 0 immediately, before the next `clk` edge.
  - → normal operation resumes on the first edge after release.
